// File: rtl/cmd_router.sv
// cmd_router: host packet engine between a byte link and the slave bus.
// Parses write/read commands, strobes writes and serializes read replies.
module cmd_router #(
   parameter int N       = 26,
   parameter int TIMEOUT = 1000
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [7:0]   master_data,
   output logic [N-1:0] valid_bus,
   output logic [N-1:0] rdreq_bus,
   input  logic [7:0]   len,
   input  logic [7:0]   slave_data,
   output logic         busy,
   output logic         err
);

   localparam int            TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [6:0]    N_ADDR = 7'(N);

   typedef enum logic [2:0] {
      IDLE,
      WR_LEN,
      WR_DATA,
      RD_HDR0,
      RD_HDR1,
      RD_DATA
   } state_t;

   state_t        state;
   logic [6:0]    addr;
   logic [7:0]    cnt;
   logic [TW-1:0] timer;
   logic [7:0]    tx_hold;

   logic          rx_addr_ok;
   logic          tx_fire;
   logic          last;
   logic          wr_state;
   logic          rd_state;
   logic          timeout_hit;
   logic [N-1:0]  addr_oh;

   // Out-of-range addresses decode to all-zero, which suppresses strobes.
   function automatic logic [N-1:0] decode(input logic [6:0] a);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) begin
         v[i] = (a == 7'(i));
      end
      return v;
   endfunction

   assign addr_oh     = decode(addr);
   assign rx_addr_ok  = (rx_data[6:0] < N_ADDR);
   assign tx_fire     = tx_valid & tx_ready;
   assign last        = (cnt == 8'd1);
   assign wr_state    = (state == WR_LEN) || (state == WR_DATA);
   assign rd_state    = (state == RD_HDR0) || (state == RD_HDR1) ||
                        (state == RD_DATA);
   assign timeout_hit = wr_state && !rx_valid && (timer == T_LAST);

   assign busy      = (state != IDLE);
   assign tx_data   = (state == RD_DATA) ? slave_data : tx_hold;
   assign rdreq_bus = (state == RD_DATA && tx_fire) ? addr_oh : '0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         addr        <= '0;
         cnt         <= '0;
         timer       <= '0;
         tx_hold     <= '0;
         tx_valid    <= 1'b0;
         master_data <= '0;
         valid_bus   <= '0;
         err         <= 1'b0;
      end else begin
         valid_bus <= '0;
         err       <= rx_valid & rd_state;
         if (wr_state && !rx_valid && !timeout_hit) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end

         unique case (state)
            IDLE: begin
               if (rx_valid) begin
                  addr <= rx_data[6:0];
                  if (rx_data[7]) begin
                     cnt      <= rx_addr_ok ? len : 8'd0;
                     tx_hold  <= {1'b1, rx_data[6:0]};
                     tx_valid <= 1'b1;
                     state    <= RD_HDR0;
                  end else begin
                     state <= WR_LEN;
                  end
               end
            end

            WR_LEN: begin
               if (rx_valid) begin
                  cnt   <= rx_data;
                  state <= (rx_data == 8'd0) ? IDLE : WR_DATA;
               end else if (timeout_hit) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end
            end

            WR_DATA: begin
               if (rx_valid) begin
                  master_data <= rx_data;
                  valid_bus   <= addr_oh;
                  cnt         <= cnt - 8'd1;
                  if (last) begin
                     state <= IDLE;
                  end
               end else if (timeout_hit) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end
            end

            RD_HDR0: begin
               if (tx_fire) begin
                  tx_hold <= cnt;
                  state   <= RD_HDR1;
               end
            end

            RD_HDR1: begin
               if (tx_fire) begin
                  if (cnt == 8'd0) begin
                     tx_valid <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     state <= RD_DATA;
                  end
               end
            end

            RD_DATA: begin
               if (tx_fire) begin
                  cnt <= cnt - 8'd1;
                  if (last) begin
                     tx_valid <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end

            default: begin
               tx_valid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
